// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time program loader. Receives a framed byte stream
//               (LEN_HI, LEN_LO, 4*N big-endian data bytes, XOR checksum)
//               over valid/ready, writes the assembled 32-bit words
//               sequentially into the instruction memory write port, and
//               holds the CPU in reset until a complete, checksum-correct
//               frame has been written.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous reset, active-low
//               start      - single-cycle load request (IDLE/DONE/ERR only)
//               in_valid   - byte-stream valid
//               in_data    - byte-stream data
//               in_ready   - loader can accept a byte
//               mem_we     - instruction memory write strobe (one cycle)
//               mem_addr   - instruction memory word address
//               mem_wdata  - instruction word
//               cpu_rst_n  - CPU reset, high only after a successful load
//               busy       - load in progress
//               done       - last load succeeded (sticky)
//               err        - last load failed (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LEN_HI = 3'd1;
    localparam logic [2:0] c_ST_LEN_LO = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_CHK    = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;
    localparam logic [2:0] c_ST_ERR    = 3'd6;

    // 17 bits so the comparison against a 16-bit length never overflows
    localparam logic [16:0] c_MAX_N = 17'(MAX_WORDS);

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [7:0]      r_acc;
    logic [7:0]      r_len_hi;
    // One bit wider than the address so N = 2^ADDR_W can be represented
    // and the final word index comparison terminates correctly.
    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] r_word_idx;
    logic [1:0]      r_byte_idx;
    logic [31:0]     r_asm;

    logic            w_busy;
    logic            w_accept;
    logic            w_start;
    logic [15:0]     w_len;
    logic            w_len_bad;
    logic            w_last_byte;
    logic [ADDR_W:0] w_word_inc;
    logic            w_last_word;
    logic            w_chk_ok;
    logic [31:0]     w_asm_next;

    assign w_busy      = (r_state == c_ST_LEN_HI) || (r_state == c_ST_LEN_LO) ||
                         (r_state == c_ST_DATA)   || (r_state == c_ST_CHK);
    assign in_ready    = w_busy;
    assign busy        = w_busy;
    assign w_accept    = in_valid && w_busy;
    // start is only honoured while no frame is in flight
    assign w_start     = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE) ||
                                   (r_state == c_ST_ERR));
    assign w_len       = {r_len_hi, in_data};
    assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > c_MAX_N);
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_word_inc  = r_word_idx + 1'b1;
    assign w_last_word = (w_word_inc == r_len);
    assign w_chk_ok    = (in_data == r_acc);
    assign w_asm_next  = {r_asm[23:0], in_data};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                if (start) w_state_next = c_ST_LEN_HI;
            end
            c_ST_LEN_HI: begin
                if (w_accept) w_state_next = c_ST_LEN_LO;
            end
            c_ST_LEN_LO: begin
                if (w_accept) w_state_next = w_len_bad ? c_ST_ERR : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_accept && w_last_byte && w_last_word) w_state_next = c_ST_CHK;
            end
            c_ST_CHK: begin
                if (w_accept) w_state_next = w_chk_ok ? c_ST_DONE : c_ST_ERR;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= 8'd0;
            r_len_hi   <= 8'd0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_asm      <= 32'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            if (w_start) begin
                r_acc     <= 8'd0;
                done      <= 1'b0;
                err       <= 1'b0;
                cpu_rst_n <= 1'b0;
            end

            // w_start and w_accept are mutually exclusive: one needs a
            // busy state, the other a non-busy state.
            if (w_accept) begin
                case (r_state)
                    c_ST_LEN_HI: begin
                        r_acc    <= r_acc ^ in_data;
                        r_len_hi <= in_data;
                    end
                    c_ST_LEN_LO: begin
                        r_acc <= r_acc ^ in_data;
                        if (w_len_bad) begin
                            err <= 1'b1;
                        end else begin
                            r_len      <= w_len[ADDR_W:0];
                            r_word_idx <= '0;
                            r_byte_idx <= 2'd0;
                        end
                    end
                    c_ST_DATA: begin
                        r_acc      <= r_acc ^ in_data;
                        r_asm      <= w_asm_next;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= r_word_idx[ADDR_W-1:0];
                            mem_wdata  <= w_asm_next;
                            r_word_idx <= w_word_inc;
                        end
                    end
                    c_ST_CHK: begin
                        if (w_chk_ok) begin
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
